// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shadow pipe of in-flight writers, bypass
// select / stall generation, multi-cycle mult/div tracker and stall counter.

module hazard_operand_scan #(
    parameter int STAGES  = 2,
    parameter int FORWARD = 1,
    parameter int FSW     = 2
) (
    input  logic [4:0]              src,
    input  logic [STAGES-1:0]       vld,
    input  logic [STAGES-1:0][4:0]  dest,
    input  logic [STAGES-1:0]       ld,
    output logic [FSW-1:0]          sel,
    output logic                    hold
);
    logic hit;

    // Youngest matching writer wins; a load still in entry 0 has no data yet.
    always_comb begin
        sel  = '0;
        hold = 1'b0;
        hit  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (!hit && src != 5'd0 && vld[k] && dest[k] == src) begin
                hit = 1'b1;
                if (FORWARD != 0 && !(k == 0 && ld[k])) sel = FSW'(k + 1);
                else hold = 1'b1;
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int STAGES  = 2,
    parameter int FORWARD = 1,
    parameter int MD_LAT  = 32,
    parameter int FSW     = $clog2(STAGES + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [31:0]     issue_insn,
    input  logic            flush,
    output logic            stall,
    output logic [FSW-1:0]  fwd_a,
    output logic [FSW-1:0]  fwd_b,
    output logic            md_busy,
    output logic            md_done,
    output logic [4:0]      md_dest,
    output logic [15:0]     stall_count
);
    localparam int CW = $clog2(MD_LAT + 1);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [4:0] op, alu, rd, rs, rt;
    logic [4:0] src_a, src_b, dst;
    logic       is_ld, is_md;

    assign op  = issue_insn[31:27];
    assign rd  = issue_insn[26:22];
    assign rs  = issue_insn[21:17];
    assign rt  = issue_insn[16:12];
    assign alu = issue_insn[6:2];

    logic unused_insn_bits;
    assign unused_insn_bits = ^{issue_insn[11:7], issue_insn[1:0]};

    always_comb begin
        src_a = '0;
        src_b = '0;
        dst   = '0;
        is_ld = 1'b0;
        is_md = 1'b0;
        case (op)
            OP_R: begin
                is_md = (alu == ALU_MUL) || (alu == ALU_DIV);
                src_a = rs;
                src_b = rt;
                if (!is_md) dst = rd;
            end
            OP_ADDI, OP_LW: begin
                src_a = rs;
                dst   = rd;
                is_ld = (op == OP_LW);
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a = rs;
                src_b = rd;
            end
            OP_JR:   src_b = rd;
            OP_JAL:  dst   = 5'd31;
            OP_SETX: dst   = 5'd30;
            OP_BEX:  src_a = 5'd30;
            default: ;
        endcase
    end

    logic [STAGES-1:0]       vld_pipe;
    logic [STAGES-1:0][4:0]  dest_pipe;
    logic [STAGES-1:0]       ld_pipe;

    logic [1:0][4:0]      srcs;
    logic [1:0][FSW-1:0]  sel;
    logic [1:0]           hold;

    assign srcs = {src_b, src_a};

    for (genvar g = 0; g < 2; g++) begin : g_scan
        hazard_operand_scan #(.STAGES(STAGES), .FORWARD(FORWARD), .FSW(FSW)) u_scan (
            .src  (srcs[g]),
            .vld  (vld_pipe),
            .dest (dest_pipe),
            .ld   (ld_pipe),
            .sel  (sel[g]),
            .hold (hold[g])
        );
    end

    logic [CW-1:0] md_cnt;
    logic          md_hz, accepted;

    assign md_busy = (md_cnt != '0);
    assign md_hz   = md_busy && (is_md
                     || (src_a != 5'd0 && src_a == md_dest)
                     || (src_b != 5'd0 && src_b == md_dest)
                     || (dst   != 5'd0 && dst   == md_dest));

    assign stall    = issue_valid && !flush && (hold[0] || hold[1] || md_hz);
    assign fwd_a    = stall ? '0 : sel[0];
    assign fwd_b    = stall ? '0 : sel[1];
    assign accepted = issue_valid && !stall && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe    <= '0;
            dest_pipe   <= '0;
            ld_pipe     <= '0;
            md_cnt      <= '0;
            md_dest     <= '0;
            md_done     <= 1'b0;
            stall_count <= '0;
        end else begin
            for (int k = STAGES - 1; k > 0; k--) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                dest_pipe[k] <= dest_pipe[k-1];
                ld_pipe[k]   <= ld_pipe[k-1];
            end
            vld_pipe[0]  <= accepted && dst != 5'd0;
            dest_pipe[0] <= dst;
            ld_pipe[0]   <= accepted && is_ld;

            md_done <= (md_cnt == CW'(1));
            if (accepted && is_md) begin
                md_cnt  <= CW'(MD_LAT);
                md_dest <= rd;
            end else if (md_busy) begin
                md_cnt <= md_cnt - CW'(1);
            end

            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised + directed bench: two scoreboard configs checked cycle by cycle
// against a rule-level model, plus a long-latency instance for counter saturation.

module tb_hazard_scoreboard;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_insn = '0;
    logic        flush = 1'b0;

    logic [1:0]       stl, busy, done;
    logic [1:0][1:0]  fa, fb;
    logic [1:0][4:0]  mdd;
    logic [1:0][15:0] sc;

    logic        iv2 = 1'b0;
    logic [31:0] ins2 = '0;
    logic        stl2, busy2, done2;
    logic [0:0]  fa2, fb2;
    logic [4:0]  mdd2;
    logic [15:0] sc2;

    localparam int SAT_LAT = 36000;

    always #5 clock = ~clock;

    hazard_scoreboard #(.STAGES(2), .FORWARD(1), .MD_LAT(4)) dut0 (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_insn(issue_insn),
        .flush(flush), .stall(stl[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .md_busy(busy[0]),
        .md_done(done[0]), .md_dest(mdd[0]), .stall_count(sc[0]));

    hazard_scoreboard #(.STAGES(3), .FORWARD(0), .MD_LAT(5)) dut1 (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_insn(issue_insn),
        .flush(flush), .stall(stl[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .md_busy(busy[1]),
        .md_done(done[1]), .md_dest(mdd[1]), .stall_count(sc[1]));

    hazard_scoreboard #(.STAGES(1), .FORWARD(1), .MD_LAT(SAT_LAT)) dut2 (
        .clock(clock), .reset(reset), .issue_valid(iv2), .issue_insn(ins2),
        .flush(1'b0), .stall(stl2), .fwd_a(fa2), .fwd_b(fb2), .md_busy(busy2),
        .md_done(done2), .md_dest(mdd2), .stall_count(sc2));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // ---- reference model: per config, list of in-flight writers (0 = none)
    int p_st[2]  = '{2, 3};
    int p_fw[2]  = '{1, 0};
    int p_lat[2] = '{4, 5};
    int m_dest[2][8];
    bit m_ld[2][8];
    int m_cnt[2], m_mdd[2], m_sc[2];
    bit m_done[2];
    bit es[2];
    int efa[2], efb[2];

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic void dec(input logic [31:0] x, output int sa, output int sb,
                                output int dst, output bit md, output bit ld);
        int op, rd, rs, rt, alu;
        op = x[31:27]; rd = x[26:22]; rs = x[21:17]; rt = x[16:12]; alu = x[6:2];
        sa = 0; sb = 0; dst = 0; md = 0; ld = 0;
        case (op)
            0:        begin sa = rs; sb = rt; dst = rd; md = (alu == 6 || alu == 7); end
            5, 8:     begin sa = rs; dst = rd; ld = (op == 8); end
            7, 2, 6:  begin sa = rs; sb = rd; end
            4:        sb = rd;
            3:        dst = 31;
            21:       dst = 30;
            22:       sa = 30;
            default:  ;
        endcase
    endfunction

    function automatic void scan(input int i, input int src, output int sel, output bit h);
        sel = 0; h = 0;
        if (src == 0) return;
        for (int k = 0; k < p_st[i]; k++) begin
            if (m_dest[i][k] == src) begin
                if (p_fw[i] != 0 && !(k == 0 && m_ld[i][k])) sel = k + 1;
                else h = 1;
                return;
            end
        end
    endfunction

    function automatic void m_eval(input int i);
        int sa, sb, dst, sela, selb;
        bit md, ld, ha, hb, mh;
        dec(issue_insn, sa, sb, dst, md, ld);
        scan(i, sa, sela, ha);
        scan(i, sb, selb, hb);
        mh = m_cnt[i] != 0 && (md || (sa != 0 && sa == m_mdd[i]) ||
             (sb != 0 && sb == m_mdd[i]) || (dst != 0 && dst == m_mdd[i]));
        es[i]  = issue_valid && !flush && (ha || hb || mh);
        efa[i] = es[i] ? 0 : sela;
        efb[i] = es[i] ? 0 : selb;
    endfunction

    function automatic void m_update(input int i);
        int sa, sb, dst;
        bit md, ld, acc;
        dec(issue_insn, sa, sb, dst, md, ld);
        acc = issue_valid && !es[i] && !flush;
        for (int k = p_st[i] - 1; k > 0; k--) begin
            m_dest[i][k] = m_dest[i][k-1];
            m_ld[i][k]   = m_ld[i][k-1];
        end
        m_dest[i][0] = (acc && !md) ? dst : 0;
        m_ld[i][0]   = acc && ld;
        m_done[i] = (m_cnt[i] == 1);
        if (acc && md) begin
            m_cnt[i] = p_lat[i];
            m_mdd[i] = issue_insn[26:22];
        end else if (m_cnt[i] > 0) m_cnt[i]--;
        if (es[i] && m_sc[i] < 65535) m_sc[i]++;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin m_dest[i][k] = 0; m_ld[i][k] = 0; end
            m_cnt[i] = 0; m_mdd[i] = 0; m_sc[i] = 0; m_done[i] = 0; es[i] = 0;
        end
    endfunction

    task automatic step(input bit iv, input logic [31:0] ins, input bit fl);
        @(negedge clock);
        issue_valid = iv; issue_insn = ins; flush = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_eval(i);
            chk($sformatf("d%0d_stall", i), stl[i], es[i]);
            chk($sformatf("d%0d_fwd_a", i), fa[i], efa[i]);
            chk($sformatf("d%0d_fwd_b", i), fb[i], efb[i]);
            chk($sformatf("d%0d_md_busy", i), busy[i], m_cnt[i] != 0);
            chk($sformatf("d%0d_md_done", i), done[i], m_done[i]);
            chk($sformatf("d%0d_md_dest", i), mdd[i], m_mdd[i]);
            chk($sformatf("d%0d_stall_count", i), sc[i], m_sc[i]);
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) m_update(i);
    endtask

    // Present an instruction until config 0 accepts it (bounded).
    task automatic issue(input logic [31:0] ins, input bit fl);
        for (int n = 0; n < 40; n++) begin
            step(1'b1, ins, fl);
            if (!es[0]) return;
        end
        chk("issue_timeout", 1, 0);
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_stall"}, stl[i], 0);
            chk({tag, "_fwd_a"}, fa[i], 0);
            chk({tag, "_fwd_b"}, fb[i], 0);
            chk({tag, "_busy"},  busy[i], 0);
            chk({tag, "_done"},  done[i], 0);
            chk({tag, "_count"}, sc[i], 0);
        end
    endtask

    function automatic logic [4:0] rr();
        case ($urandom % 6)
            0: return 5'd0;  1: return 5'd1;  2: return 5'd2;
            3: return 5'd3;  4: return 5'd30; default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rnd_insn();
        logic [4:0] ops[13];
        int k;
        ops = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd3, 5'd21, 5'd22, 5'd31};
        k = $urandom_range(0, 12);
        return mk(ops[k], rr(), rr(), rr(),
                  k == 1 ? 5'd6 : k == 2 ? 5'd7 : 5'($urandom_range(0, 5)));
    endfunction

    initial begin
        logic [31:0] cur;
        int rem, dn, ssc;
        bit ex;
        m_reset();
        issue_valid = 1'b1;
        issue_insn  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
        #12;
        chk_idle("rst");
        chk("rst_d2_busy", busy2, 0);
        @(negedge clock); reset = 1'b1;

        // directed sequences
        issue(mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0), 0);   // add r3,r1,r2
        issue(mk(5'd0, 5'd4, 5'd3, 5'd3, 5'd1), 0);   // sub r4,r3,r3
        issue(mk(5'd5, 5'd7, 5'd3, 5'd0, 5'd0), 0);   // addi r7,r3
        issue(mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0);   // lw r5
        issue(mk(5'd5, 5'd6, 5'd5, 5'd0, 5'd0), 0);   // addi r6,r5
        issue(mk(5'd0, 5'd7, 5'd3, 5'd0, 5'd0), 0);   // add r7,r3,r0
        issue(mk(5'd0, 5'd8, 5'd1, 5'd2, 5'd6), 0);   // mul r8
        issue(mk(5'd0, 5'd9, 5'd8, 5'd1, 5'd0), 0);   // add r9,r8,r1
        issue(mk(5'd0, 5'd10, 5'd1, 5'd2, 5'd7), 0);  // div r10
        issue(mk(5'd0, 5'd11, 5'd1, 5'd2, 5'd6), 0);  // mul r11 while busy
        issue(mk(5'd21, 5'd0, 5'd0, 5'd0, 5'd0), 0);  // setx
        issue(mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd0), 0);  // bex
        issue(mk(5'd21, 5'd0, 5'd0, 5'd0, 5'd0), 0);  // setx
        step(1'b1, mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd0), 1'b1);  // flushed bex
        issue(mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd0), 0);   // jal
        issue(mk(5'd4, 5'd31, 5'd0, 5'd0, 5'd0), 0);  // jr r31

        // reset mid mult with a pending dependent
        issue(mk(5'd0, 5'd12, 5'd1, 5'd2, 5'd6), 0);
        step(1'b1, mk(5'd0, 5'd13, 5'd12, 5'd3, 5'd0), 0);
        step(1'b1, mk(5'd0, 5'd13, 5'd12, 5'd3, 5'd0), 0);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        chk_idle("mid_rst");
        m_reset();
        @(negedge clock); reset = 1'b1;

        // randomised traffic; stalled instructions are mostly held
        cur = rnd_insn();
        for (int c = 0; c < 2500; c++) begin
            if (!(es[0] && issue_valid && ($urandom % 4 != 0))) cur = rnd_insn();
            step(($urandom % 100) < 85, cur, ($urandom % 100) < 10);
        end

        // saturation: back-to-back mults on the long-latency instance
        rem = 0; dn = 0; ssc = 0;
        for (int c = 0; c < 72010; c++) begin
            @(negedge clock);
            iv2 = 1'b1; ins2 = mk(5'd0, 5'd8, 5'd1, 5'd2, 5'd6);
            #1;
            ex = (rem != 0);
            chk("sat_stall", stl2, ex);
            chk("sat_done", done2, dn);
            if (c == 36001 || c == 72009) chk("sat_count", sc2, ssc);
            @(posedge clock);
            dn = (rem == 1);
            if (!ex) rem = SAT_LAT; else rem--;
            if (ex && ssc < 65535) ssc++;
        end
        chk("sat_final", sc2, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
